sprite_scheduler: RTL and testbench

SPRITE_SCHEDULER -- requirements
Module: sprite_scheduler

---
 rtl/sprite_pkg.sv | 26 ++
 rtl/sprite_scheduler_if.sv | 30 +++
 rtl/sprite_window_cmp.sv | 35 +++
 rtl/sprite_scheduler.sv | 134 +++++++++++++
 tb/tb_sprite_scheduler.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite scheduler: screen geometry, sprite size,
// bus widths and the per-sprite position/enable record.
package sprite_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int SPR_W     = 64;
  localparam int SPR_H     = 48;
  localparam int NUM_SPR   = 4;
  localparam int SPR_WORDS = 3072;

  localparam int ADDR_W  = 19;
  localparam int COORD_W = 10;
  localparam int CMP_W   = 11;
  localparam int ROM_W   = 14;
  localparam int ID_W    = 2;
  localparam int SEL_W   = 2;
  localparam int OFF_W   = 12;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               en;
  } spr_cfg_t;

endpackage

// File: rtl/sprite_scheduler_if.sv
// Pixel-strobe, sprite-config and result bus of the sprite scheduler.
// The master drives pixels and config; the slave (scheduler) drives the results.
interface sprite_scheduler_if;
  import sprite_pkg::*;

  logic               pix_valid;
  logic [ADDR_W-1:0]  pix_addr;
  logic               cfg_we;
  logic [SEL_W-1:0]   cfg_sel;
  logic [COORD_W-1:0] cfg_x;
  logic [COORD_W-1:0] cfg_y;
  logic               cfg_en;
  logic               out_valid;
  logic               out_hit;
  logic [ID_W-1:0]    out_id;
  logic [ROM_W-1:0]   out_rom_addr;
  logic               frame_start;
  logic               sync_err;

  modport master (
    output pix_valid, pix_addr, cfg_we, cfg_sel, cfg_x, cfg_y, cfg_en,
    input  out_valid, out_hit, out_id, out_rom_addr, frame_start, sync_err
  );

  modport slave (
    input  pix_valid, pix_addr, cfg_we, cfg_sel, cfg_x, cfg_y, cfg_en,
    output out_valid, out_hit, out_id, out_rom_addr, frame_start, sync_err
  );

endinterface

// File: rtl/sprite_window_cmp.sv
// Window test for one sprite: reports whether (col,row) lies inside the sprite and
// the pixel offset within the sprite bitmap.
module sprite_window_cmp
  import sprite_pkg::*;
#(
  parameter int WIN_W = SPR_W,
  parameter int WIN_H = SPR_H
) (
  input  logic [COORD_W-1:0] col,
  input  logic [COORD_W-1:0] row,
  input  spr_cfg_t           pos,
  output logic               hit,
  output logic [OFF_W-1:0]   offset
);

  localparam logic [CMP_W-1:0] W_EXT = CMP_W'(WIN_W);
  localparam logic [CMP_W-1:0] H_EXT = CMP_W'(WIN_H);
  localparam logic [OFF_W-1:0] W_OFF = OFF_W'(WIN_W);

  logic [CMP_W-1:0] col_w, row_w, x_w, y_w, dx, dy;

  // One extra bit keeps x+WIN_W from wrapping for positions near 1023.
  assign col_w = {1'b0, col};
  assign row_w = {1'b0, row};
  assign x_w   = {1'b0, pos.x};
  assign y_w   = {1'b0, pos.y};
  assign dx    = col_w - x_w;
  assign dy    = row_w - y_w;

  assign hit = pos.en && (col_w >= x_w) && (col_w < x_w + W_EXT)
                      && (row_w >= y_w) && (row_w < y_w + H_EXT);

  assign offset = OFF_W'(dy) * W_OFF + OFF_W'(dx);

endmodule

// File: rtl/sprite_scheduler.sv
// Per-pixel sprite hit/priority scheduler with shadow/active banks and a 2-stage pipeline.
// Optional macro SPRITE_SCHED_SYNC_CHECK_EN enables pixel-address sequence checking (sync_err).
module sprite_scheduler #(
  parameter int NUM_SPR = sprite_pkg::NUM_SPR,
  parameter int SPR_W   = sprite_pkg::SPR_W,
  parameter int SPR_H   = sprite_pkg::SPR_H
) (
  input logic               clk,
  input logic               reset,
  sprite_scheduler_if.slave bus
);
  import sprite_pkg::*;

  localparam logic [ROM_W-1:0] WORDS = ROM_W'(SPR_W * SPR_H);

  spr_cfg_t           shadow [NUM_SPR];
  spr_cfg_t           active [NUM_SPR];
  spr_cfg_t           eff    [NUM_SPR];
  logic               commit;
  logic [COORD_W-1:0] col_q, row_q, col_cur, row_cur;
  logic [NUM_SPR-1:0] cmp_hit, s1_hit;
  logic [OFF_W-1:0]   cmp_off [NUM_SPR];
  logic [OFF_W-1:0]   s1_off  [NUM_SPR];
  logic               s1_valid;
  logic [ID_W-1:0]    sel_id;
  logic [ROM_W-1:0]   sel_rom;

  assign commit = bus.pix_valid && (bus.pix_addr == '0);

  // The pixel at address 0 already sees the bank it commits.
  always_comb begin
    for (int i = 0; i < NUM_SPR; i++) eff[i] = commit ? shadow[i] : active[i];
  end

  always_comb begin
    col_cur = col_q + 1'b1;
    row_cur = row_q;
    if (bus.pix_addr == '0) begin
      col_cur = '0;
      row_cur = '0;
    end else if (col_q == COORD_W'(SCREEN_W - 1)) begin
      col_cur = '0;
      row_cur = row_q + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_cmp
    sprite_window_cmp #(.WIN_W(SPR_W), .WIN_H(SPR_H)) u_cmp (
      .col    (col_cur),
      .row    (row_cur),
      .pos    (eff[g]),
      .hit    (cmp_hit[g]),
      .offset (cmp_off[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (commit) begin
        for (int i = 0; i < NUM_SPR; i++) active[i] <= shadow[i];
      end
      if (bus.cfg_we) shadow[bus.cfg_sel] <= {bus.cfg_x, bus.cfg_y, bus.cfg_en};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (bus.pix_valid) begin
      col_q <= col_cur;
      row_q <= row_cur;
    end
  end

  always_comb begin
    sel_id  = '0;
    sel_rom = '0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        sel_id  = ID_W'(i);
        sel_rom = ROM_W'(i) * WORDS + ROM_W'(s1_off[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid         <= 1'b0;
      s1_hit           <= '0;
      for (int i = 0; i < NUM_SPR; i++) s1_off[i] <= '0;
      bus.frame_start  <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.out_hit      <= 1'b0;
      bus.out_id       <= '0;
      bus.out_rom_addr <= '0;
    end else begin
      s1_valid         <= bus.pix_valid;
      s1_hit           <= cmp_hit;
      for (int i = 0; i < NUM_SPR; i++) s1_off[i] <= cmp_off[i];
      bus.frame_start  <= commit;
      bus.out_valid    <= s1_valid;
      bus.out_hit      <= |s1_hit;
      bus.out_id       <= sel_id;
      bus.out_rom_addr <= sel_rom;
    end
  end

`ifdef SPRITE_SCHED_SYNC_CHECK_EN
  logic [ADDR_W-1:0] exp_addr;
  logic              s1_err;

  // Expected address keeps counting through a mismatch; only address 0 resyncs it.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_addr     <= ADDR_W'(1);
      s1_err       <= 1'b0;
      bus.sync_err <= 1'b0;
    end else begin
      if (bus.pix_valid) exp_addr <= commit ? ADDR_W'(1) : exp_addr + 1'b1;
      s1_err       <= bus.pix_valid && !commit && (bus.pix_addr != exp_addr);
      bus.sync_err <= s1_err;
    end
  end
`else
  assign bus.sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_scheduler.sv
// Scoreboard bench for sprite_scheduler: a divide-based reference model pushes expected
// results per pixel, a negedge monitor pops them when out_valid appears.
module tb_sprite_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sprite_scheduler_if bus ();

  sprite_scheduler #(.NUM_SPR(4), .SPR_W(64), .SPR_H(48)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          addr;
    logic        hit;
    logic [1:0]  id;
    logic [13:0] rom;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  logic fs_exp = 1'b0;
  int   m_idx = 0;
  int   sh_x[4], sh_y[4], ac_x[4], ac_y[4];
  logic sh_en[4], ac_en[4];

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_en[i] = 1'b0;
      ac_x[i] = 0; ac_y[i] = 0; ac_en[i] = 1'b0;
    end
    m_idx = 0;
  endtask

  // One clock of stimulus; the model uses divide/modulo on its own linear index.
  task automatic step(input logic pv, input int addr, input logic we = 1'b0,
                      input int sel = 0, input int x = 0, input int y = 0,
                      input logic en = 1'b0);
    exp_t e;
    int idx, col, row;
    bus.pix_valid = pv;
    bus.pix_addr  = 19'(addr);
    bus.cfg_we    = we;
    bus.cfg_sel   = 2'(sel);
    bus.cfg_x     = 10'(x);
    bus.cfg_y     = 10'(y);
    bus.cfg_en    = en;
    if (pv) begin
      idx   = (addr == 0) ? 0 : m_idx + 1;
      e.err = 1'b0;
`ifdef SPRITE_SCHED_SYNC_CHECK_EN
      e.err = (addr != 0) && (addr != idx);
`endif
      m_idx = idx;
      if (addr == 0) begin
        for (int i = 0; i < 4; i++) begin
          ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_en[i] = sh_en[i];
        end
      end
      col = idx % 640;
      row = idx / 640;
      e.addr = addr; e.hit = 1'b0; e.id = 2'd0; e.rom = 14'd0;
      for (int i = 3; i >= 0; i--) begin
        if (ac_en[i] && col >= ac_x[i] && col < ac_x[i] + 64 &&
            row >= ac_y[i] && row < ac_y[i] + 48) begin
          e.hit = 1'b1;
          e.id  = 2'(i);
          e.rom = 14'(i * 3072 + (row - ac_y[i]) * 64 + (col - ac_x[i]));
        end
      end
      sb.push_back(e);
    end
    if (we) begin
      sh_x[sel] = x; sh_y[sel] = y; sh_en[sel] = en;
    end
    @(posedge clk);
    #1;
    fs_exp = pv && (addr == 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.pix_valid = 1'b0; bus.pix_addr = '0; bus.cfg_we = 1'b0;
    bus.cfg_sel = '0; bus.cfg_x = '0; bus.cfg_y = '0; bus.cfg_en = 1'b0;
    @(posedge clk);
    #1;
    fs_exp = 1'b0;
    sb.delete();
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    total++;
    if (bus.frame_start !== fs_exp) begin
      bad++;
      $display("[TB] FAIL frame_start got=%0b want=%0b at %0t", bus.frame_start, fs_exp, $time);
    end
    if (bus.out_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_out_valid with empty scoreboard at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        if ({bus.out_hit, bus.out_id, bus.out_rom_addr, bus.sync_err} !==
            {mon_e.hit, mon_e.id, mon_e.rom, mon_e.err}) begin
          bad++;
          $display("[TB] FAIL pixel addr=%0d got hit=%0b id=%0d rom=%0d err=%0b want hit=%0b id=%0d rom=%0d err=%0b",
                   mon_e.addr, bus.out_hit, bus.out_id, bus.out_rom_addr, bus.sync_err,
                   mon_e.hit, mon_e.id, mon_e.rom, mon_e.err);
        end
      end
    end
  end

  task automatic test_reset();
    apply_reset();
    total++;
    if ({bus.out_valid, bus.out_hit, bus.out_id, bus.out_rom_addr, bus.frame_start, bus.sync_err} !== 20'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got valid=%0b hit=%0b id=%0d rom=%0d fs=%0b err=%0b want all 0",
               bus.out_valid, bus.out_hit, bus.out_id, bus.out_rom_addr, bus.frame_start, bus.sync_err);
    end
  endtask

  task automatic test_single_hit();
    apply_reset();
    step(1'b0, 0, 1'b1, 1, 100, 50, 1'b1);
    for (int a = 0; a <= 32164; a++) step(1'b1, a);
    for (int k = 0; k < 3; k++) step(1'b0, 0);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("[TB] FAIL single_hit_drain got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_priority();
    apply_reset();
    step(1'b0, 0, 1'b1, 0, 0, 0, 1'b1);
    step(1'b0, 0, 1'b1, 2, 0, 0, 1'b1);
    for (int a = 0; a <= 3210; a++) step(1'b1, a);
    for (int k = 0; k < 3; k++) step(1'b0, 0);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("[TB] FAIL priority_drain got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_mid_frame_write();
    apply_reset();
    step(1'b1, 0);
    step(1'b0, 0, 1'b1, 3, 0, 0, 1'b1);
    step(1'b1, 1);
    step(1'b1, 2);
    step(1'b1, 0);
    total++;
    if (bus.frame_start !== 1'b1) begin
      bad++;
      $display("[TB] FAIL commit_pulse got=%0b want=1", bus.frame_start);
    end
    step(1'b1, 1);
    for (int k = 0; k < 3; k++) step(1'b0, 0);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("[TB] FAIL mid_write_drain got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_commit_collision();
    apply_reset();
    step(1'b0, 0, 1'b1, 0, 0, 0, 1'b1);
    step(1'b1, 0, 1'b1, 0, 5, 0, 1'b1);
    step(1'b1, 1);
    step(1'b1, 2);
    step(1'b1, 0);
    for (int a = 1; a <= 6; a++) step(1'b1, a);
    for (int k = 0; k < 3; k++) step(1'b0, 0);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("[TB] FAIL collision_drain got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_idle_gaps();
    apply_reset();
    step(1'b0, 0, 1'b1, 1, 2, 0, 1'b1);
    step(1'b1, 0);
    step(1'b0, 0, 1'b1, 1, 0, 0, 1'b1);
    step(1'b1, 1);
    step(1'b0, 0);
    step(1'b0, 0);
    step(1'b1, 2);
    step(1'b1, 3);
    for (int k = 0; k < 3; k++) step(1'b0, 0);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("[TB] FAIL idle_drain got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_sync();
    apply_reset();
    step(1'b0, 0, 1'b1, 0, 0, 0, 1'b1);
    step(1'b1, 0);
    step(1'b1, 1);
    step(1'b1, 2);
    step(1'b1, 5);
    step(1'b1, 0);
    step(1'b1, 1);
    for (int k = 0; k < 3; k++) step(1'b0, 0);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("[TB] FAIL sync_drain got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    step(1'b0, 0, 1'b1, 0, 0, 0, 1'b1);
    step(1'b1, 0);
    step(1'b1, 1);
    apply_reset();
    total++;
    if ({bus.out_valid, bus.out_hit, bus.out_id, bus.out_rom_addr, bus.frame_start, bus.sync_err} !== 20'd0) begin
      bad++;
      $display("[TB] FAIL mid_reset_outputs got valid=%0b hit=%0b id=%0d rom=%0d want all 0",
               bus.out_valid, bus.out_hit, bus.out_id, bus.out_rom_addr);
    end
    step(1'b0, 0);
    step(1'b0, 0);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL post_reset_quiet got out_valid=%0b want 0", bus.out_valid);
    end
    step(1'b1, 0);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL post_reset_latency1 got out_valid=%0b want 0", bus.out_valid);
    end
    step(1'b0, 0);
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL post_reset_latency2 got out_valid=%0b want 1", bus.out_valid);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 0);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("[TB] FAIL mid_reset_drain got pending=%0d want 0", sb.size());
    end
  endtask

  initial begin
    model_clear();
    bus.pix_valid = 1'b0; bus.pix_addr = '0; bus.cfg_we = 1'b0;
    bus.cfg_sel = '0; bus.cfg_x = '0; bus.cfg_y = '0; bus.cfg_en = 1'b0;
    $display("[TB] starting sprite_scheduler bench");
    test_reset();
    test_single_hit();
    test_priority();
    test_mid_frame_write();
    test_commit_collision();
    test_idle_gaps();
    test_sync();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
